// File: rtl/es_pool_scheduler.sv
// Round-robin scheduler feeding entropy-source bits into the conditioner pool.
// Grants one eligible source per cycle and holds the full pool until the conditioner dequeues it.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_COLLECT | granting sources, shifting one bit per grant into the pool
//   S_FULL    | pool holds COND_WIDTH bits, waiting for deque
//   S_FAULT   | no usable source exists, fill_count retained
module es_pool_scheduler #(
  parameter int ES_SOURCES = 64,
  parameter int COND_WIDTH = 384,
  localparam int PTR_W     = $clog2(ES_SOURCES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ES_SOURCES-1:0] es_bit,
  input  logic [ES_SOURCES-1:0] es_valid,
  input  logic [ES_SOURCES-1:0] perm_fail,
  input  logic [ES_SOURCES-1:0] src_mask,
  input  logic                  debug_mode,
  input  logic [PTR_W-1:0]      debug_src,
  input  logic                  deque,
  output logic [ES_SOURCES-1:0] ack,
  output logic [COND_WIDTH-1:0] cond_out,
  output logic                  full,
  output logic                  empty,
  output logic [8:0]            fill_count,
  output logic                  all_fail
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_FULL    = 2'd1,
    S_FAULT   = 2'd2
  } state_t;

  localparam logic [8:0] FILL_MAX = 9'(COND_WIDTH);

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        ptr, ptr_nxt;
  logic [8:0]              fill_nxt;
  logic [COND_WIDTH-1:0]   pool_nxt;
  logic                    debug_mode_q;
  logic                    mode_chg;

  logic [ES_SOURCES-1:0]   healthy;
  logic [ES_SOURCES-1:0]   dbg_oh;
  logic [ES_SOURCES-1:0]   elig;
  logic [2*ES_SOURCES-1:0] elig_dbl;
  logic [ES_SOURCES-1:0]   elig_rot;
  logic [PTR_W-1:0]        grant_off;
  logic [PTR_W-1:0]        grant_idx;
  logic                    grant_any;
  logic                    fault_cond;
  logic                    grant_ok;

  assign mode_chg = debug_mode ^ debug_mode_q;
  assign healthy  = ~perm_fail & src_mask;

  always_comb begin
    dbg_oh            = '0;
    dbg_oh[debug_src] = 1'b1;
    elig              = es_valid & healthy;
    if (debug_mode) begin
      elig = elig & dbg_oh;
    end
  end

  assign fault_cond = debug_mode ? ~healthy[debug_src] : ~|healthy;

  // Rotate so that ptr sits at bit 0; the lowest set bit is then the next source in round-robin order.
  assign elig_dbl = {elig, elig} >> ptr;
  assign elig_rot = elig_dbl[ES_SOURCES-1:0];

  always_comb begin
    grant_off = '0;
    for (int i = ES_SOURCES - 1; i >= 0; i--) begin
      if (elig_rot[i]) begin
        grant_off = PTR_W'(i);
      end
    end
  end

  assign grant_idx = ptr + grant_off;
  assign grant_any = |elig;

  // Reset gates the grant directly so no ack leaks out while rst is held low.
  assign grant_ok = rst && (state == S_COLLECT) && !mode_chg && !fault_cond && grant_any;

  always_comb begin
    ack = '0;
    if (grant_ok) begin
      ack[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_count;
    ptr_nxt   = ptr;
    pool_nxt  = cond_out;
    case (state)
      S_COLLECT: begin
        if (mode_chg) begin
          fill_nxt = '0;
          if (fault_cond) begin
            state_nxt = S_FAULT;
          end
        end else if (fault_cond) begin
          state_nxt = S_FAULT;
        end else if (grant_any) begin
          pool_nxt = {cond_out[COND_WIDTH-2:0], es_bit[grant_idx]};
          ptr_nxt  = grant_idx + 1'b1;
          if (fill_count != FILL_MAX) begin
            fill_nxt = fill_count + 9'd1;
          end
          if (fill_count + 9'd1 >= FILL_MAX) begin
            state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (deque) begin
          fill_nxt  = '0;
          state_nxt = S_COLLECT;
        end
      end
      S_FAULT: begin
        if (!fault_cond) begin
          state_nxt = S_COLLECT;
        end
      end
      default: begin
        state_nxt = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= '0;
      fill_count   <= '0;
      cond_out     <= '0;
      debug_mode_q <= 1'b0;
    end else begin
      ptr          <= ptr_nxt;
      fill_count   <= fill_nxt;
      cond_out     <= pool_nxt;
      debug_mode_q <= debug_mode;
    end
  end

  assign full     = (state == S_FULL);
  assign all_fail = (state == S_FAULT);
  assign empty    = (fill_count == 9'd0);

endmodule

// File: tb/tb_es_pool_scheduler.sv
// Directed bench for es_pool_scheduler: table of single-cycle grant vectors
// followed by hand-written sequences for full/deque, fault, debug and reset.
module tb_es_pool_scheduler;

  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] LSB_PAT = 64'hAAAA_AAAA_AAAA_AAAA;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  es_bit, es_valid, perm_fail, src_mask;
  logic         debug_mode;
  logic [5:0]   debug_src;
  logic         deque;
  logic [63:0]  ack;
  logic [383:0] cond_out;
  logic         full, empty, all_fail;
  logic [8:0]   fill_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] valid;
    logic [63:0] pf;
    logic [63:0] mask;
    logic [63:0] exp_ack;
    logic [8:0]  exp_fill;
    logic        exp_fail;
  } vec_t;

  vec_t tbl [11];

  es_pool_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .es_bit     (es_bit),
    .es_valid   (es_valid),
    .perm_fail  (perm_fail),
    .src_mask   (src_mask),
    .debug_mode (debug_mode),
    .debug_src  (debug_src),
    .deque      (deque),
    .ack        (ack),
    .cond_out   (cond_out),
    .full       (full),
    .empty      (empty),
    .fill_count (fill_count),
    .all_fail   (all_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst        = 1'b0;
    es_bit     = LSB_PAT;
    es_valid   = ALL;
    perm_fail  = '0;
    src_mask   = ALL;
    debug_mode = 1'b0;
    debug_src  = '0;
    deque      = 1'b0;
    tick();
    #1;
    rst = 1'b1;
  endtask

  function automatic int next_src(input int from, input logic [63:0] el);
    for (int k = 0; k < 64; k++) begin
      if (el[(from + k) % 64]) return (from + k) % 64;
    end
    return -1;
  endfunction

  logic [383:0] pat;
  logic [383:0] pool_m;
  logic [63:0]  el_m;
  int           ptr_m;
  int           src;
  int           waited;

  initial begin
    for (int i = 0; i < 384; i++) pat[i] = (i % 2 == 0);

    tbl[0]  = '{ALL,            '0,  ALL,                          64'd1 << 0,  9'd1, 1'b0};
    tbl[1]  = '{ALL,            '0,  ALL,                          64'd1 << 1,  9'd2, 1'b0};
    tbl[2]  = '{64'd1,          '0,  ALL,                          64'd1 << 0,  9'd3, 1'b0};
    tbl[3]  = '{64'd0,          '0,  ALL,                          64'd0,       9'd3, 1'b0};
    tbl[4]  = '{ALL,            64'd1 << 1, ALL,                   64'd1 << 2,  9'd4, 1'b0};
    tbl[5]  = '{ALL,            '0,  ALL & ~(64'd3 << 3),          64'd1 << 5,  9'd5, 1'b0};
    tbl[6]  = '{(64'd1 << 63) | (64'd1 << 2), '0, ALL,             64'd1 << 63, 9'd6, 1'b0};
    tbl[7]  = '{(64'd1 << 63) | (64'd1 << 2), '0, ALL,             64'd1 << 2,  9'd7, 1'b0};
    tbl[8]  = '{ALL,            ALL, ALL,                          64'd0,       9'd7, 1'b1};
    tbl[9]  = '{ALL,            '0,  ALL,                          64'd0,       9'd7, 1'b0};
    tbl[10] = '{ALL,            '0,  ALL,                          64'd1 << 3,  9'd8, 1'b0};

    // Reset values, checked while rst is still low with every source valid.
    rst = 1'b0;
    es_bit = LSB_PAT; es_valid = ALL; perm_fail = '0; src_mask = ALL;
    debug_mode = 1'b0; debug_src = '0; deque = 1'b0;
    tick();
    chk("rst_ack", ack, '0);
    chk("rst_fill", fill_count, '0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_all_fail", all_fail, 1'b0);
    chk("rst_cond_out", cond_out, '0);
    #1;
    rst = 1'b1;

    // Grant vectors starting from ptr=0.
    for (int i = 0; i < 11; i++) begin
      es_valid  = tbl[i].valid;
      perm_fail = tbl[i].pf;
      src_mask  = tbl[i].mask;
      #1;
      chk($sformatf("vec%0d_ack", i), ack, tbl[i].exp_ack);
      tick();
      chk($sformatf("vec%0d_fill", i), fill_count, tbl[i].exp_fill);
      chk($sformatf("vec%0d_all_fail", i), all_fail, tbl[i].exp_fail);
    end

    // Full rotation with every source valid, then hold and deque.
    apply_reset();
    for (int k = 0; k < 384; k++) begin
      #1;
      chk($sformatf("rot_ack_%0d", k), ack, 64'd1 << (k % 64));
      tick();
    end
    chk("rot_full", full, 1'b1);
    chk("rot_fill", fill_count, 9'd384);
    chk("rot_pool", cond_out, pat);
    for (int k = 0; k < 50; k++) begin
      #1;
      chk("hold_ack", ack, '0);
      tick();
      chk("hold_pool", cond_out, pat);
    end
    chk("hold_fill", fill_count, 9'd384);
    deque = 1'b1;
    #1;
    chk("deque_ack", ack, '0);
    tick();
    deque = 1'b0;
    chk("deque_empty", empty, 1'b1);
    chk("deque_full", full, 1'b0);
    chk("deque_pool_kept", cond_out, pat);

    // Skipping a failed and a masked source; pool and saved ptr tracked by a small model.
    apply_reset();
    perm_fail[5] = 1'b1;
    src_mask[10] = 1'b0;
    el_m   = ALL & ~(64'd1 << 5) & ~(64'd1 << 10);
    ptr_m  = 0;
    pool_m = '0;
    for (int k = 0; k < 384; k++) begin
      #1;
      src = next_src(ptr_m, el_m);
      chk($sformatf("skip_ack_%0d", k), ack, 64'd1 << src);
      tick();
      pool_m = {pool_m[382:0], es_bit[src]};
      ptr_m  = (src + 1) % 64;
    end
    chk("skip_full", full, 1'b1);
    chk("skip_pool", cond_out, pool_m);
    deque = 1'b1;
    tick();
    deque = 1'b0;
    #1;
    chk("skip_resume_ack", ack, 64'd1 << 14);

    // All sources failing mid-fill.
    apply_reset();
    repeat (100) tick();
    chk("fault_pre_fill", fill_count, 9'd100);
    perm_fail = ALL;
    #1;
    chk("fault_ack", ack, '0);
    tick();
    chk("fault_all_fail", all_fail, 1'b1);
    repeat (5) tick();
    chk("fault_hold_fill", fill_count, 9'd100);
    chk("fault_hold_flag", all_fail, 1'b1);
    perm_fail = '0;
    tick();
    chk("fault_clear", all_fail, 1'b0);
    chk("fault_clear_fill", fill_count, 9'd100);
    waited = 0;
    while (!full && waited < 400) begin
      tick();
      waited++;
    end
    chk("fault_refill_full", full, 1'b1);
    chk("fault_refill_fill", fill_count, 9'd384);

    // Debug mode flush, single-source collection, ignored deque, then reset mid-fill.
    apply_reset();
    repeat (20) tick();
    chk("dbg_pre_fill", fill_count, 9'd20);
    debug_mode = 1'b1;
    debug_src  = 6'd40;
    #1;
    chk("dbg_switch_ack", ack, '0);
    tick();
    chk("dbg_flush_fill", fill_count, 9'd0);
    for (int k = 0; k < 10; k++) begin
      deque = (k == 5);
      #1;
      chk($sformatf("dbg_ack_%0d", k), ack, 64'd1 << 40);
      tick();
    end
    deque = 1'b0;
    chk("dbg_fill", fill_count, 9'd10);
    rst = 1'b0;
    #1;
    chk("midrst_fill", fill_count, '0);
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_full", full, 1'b0);
    chk("midrst_all_fail", all_fail, 1'b0);
    chk("midrst_ack", ack, '0);
    chk("midrst_pool", cond_out, '0);
    tick();
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
